// File: rtl/status_register_pipe_pkg.sv
// Shared constants for the condition-code status register: flag bit positions,
// saved-bank identifiers and the bank-select width helper.
package status_register_pipe_pkg;

  localparam int FLAG_W_DEF = 4;

  // Condition-code bit positions; carry is at bit 2.
  localparam int FLAG_V = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 3;

  localparam int BANK_USR = 0;
  localparam int BANK_IRQ = 1;
  localparam int BANK_FIQ = 2;
  localparam int BANK_SVC = 3;

  function automatic int bank_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/status_pending_pipe.sv
// Chain of uncommitted flag writes: shifts one stage per edge, kill clears every
// stage, and the youngest valid stage is forwarded to the condition evaluator.
module status_pending_pipe #(
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              load,
  input  logic [FLAG_W-1:0] load_data,
  input  logic              kill,
  output logic              commit_vld,
  output logic [FLAG_W-1:0] commit_data,
  output logic              fwd_vld,
  output logic [FLAG_W-1:0] fwd_data,
  output logic              busy
);

  generate
    if (DEPTH == 1) begin : g_direct
      // Single-register behaviour: the write goes straight into the committed flags.
      assign commit_vld  = load & ~kill;
      assign commit_data = load_data;
      assign fwd_vld     = 1'b0;
      assign fwd_data    = '0;
      assign busy        = 1'b0;
    end else begin : g_pipe
      localparam int STAGES = DEPTH - 1;

      logic [STAGES-1:0]             vld_pipe;
      logic [STAGES-1:0][FLAG_W-1:0] data_pipe;

      always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
          vld_pipe  <= '0;
          data_pipe <= '0;
        end else begin
          vld_pipe[0]  <= load & ~kill;
          data_pipe[0] <= load_data;
          for (int i = 1; i < STAGES; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1] & ~kill;
            data_pipe[i] <= data_pipe[i-1];
          end
        end
      end

      // Entry leaving the last stage is dropped if the chain is killed on this edge.
      assign commit_vld  = vld_pipe[STAGES-1] & ~kill;
      assign commit_data = data_pipe[STAGES-1];
      assign busy        = |vld_pipe;

      // Scan oldest to youngest so the lowest valid index wins.
      always_comb begin
        fwd_vld  = 1'b0;
        fwd_data = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
          if (vld_pipe[i]) begin
            fwd_vld  = 1'b1;
            fwd_data = data_pipe[i];
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/status_register_pipe.sv
// Condition-code status register with delayed commit, in-flight forwarding and
// banked save/restore for exception entry and return.
module status_register_pipe
  import status_register_pipe_pkg::*;
#(
  parameter int FLAG_W    = FLAG_W_DEF,
  parameter int CARRY_BIT = FLAG_C,
  parameter int NUM_BANKS = 4,
  parameter int DEPTH     = 2
) (
  input  logic                           CLK,
  input  logic                           CLR,
  input  logic [FLAG_W-1:0]              CC,
  input  logic                           S,
  input  logic                           flush,
  input  logic                           save_en,
  input  logic [bank_w(NUM_BANKS)-1:0]   save_bank,
  input  logic                           restore_en,
  input  logic [bank_w(NUM_BANKS)-1:0]   restore_bank,
  input  logic [bank_w(NUM_BANKS)-1:0]   rd_bank,
  output logic [FLAG_W-1:0]              Real_CC,
  output logic                           Carry,
  output logic [FLAG_W-1:0]              Fwd_CC,
  output logic                           Fwd_Carry,
  output logic                           flags_busy,
  output logic [FLAG_W-1:0]              rd_data
);

  localparam int            BW = bank_w(NUM_BANKS);
  localparam logic [BW:0]   NB = (BW + 1)'(NUM_BANKS);

  logic [NUM_BANKS-1:0][FLAG_W-1:0] banks;
  logic              commit_vld, fwd_vld;
  logic [FLAG_W-1:0] commit_data, fwd_data;
  logic              save_ok, restore_ok, rd_ok;

  assign save_ok    = {1'b0, save_bank} < NB;
  assign restore_ok = {1'b0, restore_bank} < NB;
  assign rd_ok      = {1'b0, rd_bank} < NB;

  // Restore also discards in-flight writes, even when its bank index is invalid.
  status_pending_pipe #(.FLAG_W(FLAG_W), .DEPTH(DEPTH)) u_pend (
    .CLK         (CLK),
    .CLR         (CLR),
    .load        (S),
    .load_data   (CC),
    .kill        (flush | restore_en),
    .commit_vld  (commit_vld),
    .commit_data (commit_data),
    .fwd_vld     (fwd_vld),
    .fwd_data    (fwd_data),
    .busy        (flags_busy)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      Real_CC <= '0;
      Carry   <= 1'b0;
      banks   <= '0;
    end else begin
      if (restore_en) begin
        if (restore_ok) begin
          Real_CC <= banks[restore_bank];
          Carry   <= banks[restore_bank][CARRY_BIT];
        end
      end else if (commit_vld) begin
        Real_CC <= commit_data;
        Carry   <= commit_data[CARRY_BIT];
      end
      // Save captures the pre-edge committed flags; a same-bank restore reads the old bank.
      if (save_en && save_ok)
        banks[save_bank] <= Real_CC;
    end
  end

  assign Fwd_CC    = fwd_vld ? fwd_data : Real_CC;
  assign Fwd_Carry = Fwd_CC[CARRY_BIT];
  assign rd_data   = rd_ok ? banks[rd_bank] : '0;

endmodule

// File: tb/tb_status_register_pipe.sv
// Bench for status_register_pipe: DEPTH=2 and DEPTH=3 instances share stimulus;
// directed scenarios plus a queue scoreboard for back-to-back writes.
module tb_status_register_pipe;

  logic       CLK, CLR, S, flush, save_en, restore_en;
  logic [3:0] CC;
  logic [1:0] save_bank, restore_bank, rd_bank;

  logic [3:0] r2, f2, d2, r3, f3, d3;
  logic       c2, fc2, b2, c3, fc3, b3;

  int checks = 0;
  int errors = 0;

  status_register_pipe #(.DEPTH(2)) u2 (
    .CLK(CLK), .CLR(CLR), .CC(CC), .S(S), .flush(flush),
    .save_en(save_en), .save_bank(save_bank),
    .restore_en(restore_en), .restore_bank(restore_bank), .rd_bank(rd_bank),
    .Real_CC(r2), .Carry(c2), .Fwd_CC(f2), .Fwd_Carry(fc2),
    .flags_busy(b2), .rd_data(d2)
  );

  status_register_pipe #(.DEPTH(3)) u3 (
    .CLK(CLK), .CLR(CLR), .CC(CC), .S(S), .flush(flush),
    .save_en(save_en), .save_bank(save_bank),
    .restore_en(restore_en), .restore_bank(restore_bank), .rd_bank(rd_bank),
    .Real_CC(r3), .Carry(c3), .Fwd_CC(f3), .Fwd_Carry(fc3),
    .flags_busy(b3), .rd_data(d3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    S = 0; CC = '0; flush = 0; save_en = 0; restore_en = 0;
    save_bank = '0; restore_bank = '0; rd_bank = '0;
  endtask

  task automatic do_reset();
    idle();
    CLR = 1;
    #2;
    CLR = 0;
  endtask

  task automatic set_real(input logic [3:0] v);
    CC = v; S = 1;
    step();
    S = 0;
    step();
    step();
  endtask

  task automatic test_reset();
    idle();
    CLR = 1;
    #3;
    checks++; if (r2 !== 4'h0 || c2 !== 1'b0) begin errors++; $display("FAIL reset_real2 got %b/%b exp 0000/0", r2, c2); end
    checks++; if (f3 !== 4'h0 || b3 !== 1'b0 || d3 !== 4'h0) begin errors++; $display("FAIL reset_misc3 got f=%b b=%b d=%b exp 0000/0/0000", f3, b3, d3); end
    CLR = 0;
    step();
    // Async clear between edges with writes in flight
    CC = 4'b1111; S = 1;
    step();
    S = 0;
    checks++; if (b3 !== 1'b1) begin errors++; $display("FAIL pre_clr_busy got %b exp 1", b3); end
    #2 CLR = 1;
    #1;
    checks++; if (r3 !== 4'h0 || c3 !== 1'b0 || b3 !== 1'b0 || b2 !== 1'b0) begin errors++; $display("FAIL async_clr got r=%b c=%b b3=%b b2=%b exp 0000/0/0/0", r3, c3, b3, b2); end
    CLR = 0;
    step();
    step();
    checks++; if (r3 !== 4'h0 || r2 !== 4'h0) begin errors++; $display("FAIL clr_no_commit got r3=%b r2=%b exp 0000", r3, r2); end
  endtask

  task automatic test_depth2();
    do_reset();
    CC = 4'b0101; S = 1;
    step();
    S = 0;
    checks++; if (f2 !== 4'b0101 || b2 !== 1'b1 || r2 !== 4'h0) begin errors++; $display("FAIL d2_fwd got f=%b b=%b r=%b exp 0101/1/0000", f2, b2, r2); end
    checks++; if (fc2 !== 1'b1) begin errors++; $display("FAIL d2_fwd_carry got %b exp 1", fc2); end
    step();
    checks++; if (r2 !== 4'b0101 || c2 !== 1'b1 || b2 !== 1'b0) begin errors++; $display("FAIL d2_commit got r=%b c=%b b=%b exp 0101/1/0", r2, c2, b2); end
  endtask

  task automatic test_depth3();
    do_reset();
    CC = 4'b1011; S = 1;
    step();
    CC = 4'b0010;
    step();
    S = 0;
    checks++; if (f3 !== 4'b0010 || r3 !== 4'h0) begin errors++; $display("FAIL d3_youngest got f=%b r=%b exp 0010/0000", f3, r3); end
    step();
    checks++; if (r3 !== 4'b1011 || c3 !== 1'b0 || f3 !== 4'b0010) begin errors++; $display("FAIL d3_first got r=%b c=%b f=%b exp 1011/0/0010", r3, c3, f3); end
    step();
    checks++; if (r3 !== 4'b0010 || b3 !== 1'b0) begin errors++; $display("FAIL d3_second got r=%b b=%b exp 0010/0", r3, b3); end
  endtask

  task automatic test_flush();
    do_reset();
    CC = 4'b1111; S = 1;
    step();
    CC = 4'b0001; flush = 1;
    step();
    flush = 0; S = 0;
    checks++; if (b3 !== 1'b0 || r3 !== 4'h0 || r2 !== 4'h0 || b2 !== 1'b0) begin errors++; $display("FAIL flush got b3=%b r3=%b r2=%b b2=%b exp 0/0000/0000/0", b3, r3, r2, b2); end
    step();
    step();
    checks++; if (r3 !== 4'h0 || f3 !== 4'h0) begin errors++; $display("FAIL flush_late got r=%b f=%b exp 0000/0000", r3, f3); end
  endtask

  task automatic test_save_restore();
    do_reset();
    set_real(4'b0110);
    save_en = 1; save_bank = 2'd2;
    step();
    save_en = 0;
    CC = 4'b1000; S = 1; restore_en = 1; restore_bank = 2'd2;
    step();
    S = 0; restore_en = 0; rd_bank = 2'd2;
    #1;
    checks++; if (r3 !== 4'b0110 || c3 !== 1'b1 || b3 !== 1'b0) begin errors++; $display("FAIL restore got r=%b c=%b b=%b exp 0110/1/0", r3, c3, b3); end
    checks++; if (d3 !== 4'b0110 || d2 !== 4'b0110) begin errors++; $display("FAIL rd_bank2 got %b/%b exp 0110", d3, d2); end
    step();
    step();
    checks++; if (r3 !== 4'b0110 || r2 !== 4'b0110) begin errors++; $display("FAIL restore_drop got r3=%b r2=%b exp 0110", r3, r2); end
  endtask

  task automatic test_same_bank();
    do_reset();
    set_real(4'b1100);
    save_en = 1; save_bank = 2'd1;
    step();
    save_en = 0;
    set_real(4'b0011);
    save_en = 1; save_bank = 2'd1; restore_en = 1; restore_bank = 2'd1;
    step();
    save_en = 0; restore_en = 0; rd_bank = 2'd1;
    #1;
    checks++; if (r3 !== 4'b1100 || c3 !== 1'b1) begin errors++; $display("FAIL same_bank_real got r=%b c=%b exp 1100/1", r3, c3); end
    checks++; if (d3 !== 4'b0011) begin errors++; $display("FAIL same_bank_save got %b exp 0011", d3); end
  endtask

  task automatic test_save_vs_commit();
    do_reset();
    CC = 4'b1001; S = 1;
    step();
    S = 0; save_en = 1; save_bank = 2'd3;
    step();
    save_en = 0; rd_bank = 2'd3;
    #1;
    checks++; if (r2 !== 4'b1001 || d2 !== 4'b0000) begin errors++; $display("FAIL save_pre_edge got r=%b bank=%b exp 1001/0000", r2, d2); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] q2[$];
    logic [3:0] q3[$];
    logic [3:0] v, e;
    do_reset();
    for (int k = 0; k < 24; k++) begin
      v = 4'($urandom_range(0, 15));
      CC = v; S = 1;
      q2.push_back(v);
      q3.push_back(v);
      step();
      checks++; if (f3 !== v || f2 !== v) begin errors++; $display("FAIL b2b_fwd got %b/%b exp %b", f2, f3, v); end
      if (q2.size() > 1) begin
        e = q2.pop_front();
        checks++; if (r2 !== e || c2 !== e[2]) begin errors++; $display("FAIL b2b_real2 got %b exp %b", r2, e); end
      end
      if (q3.size() > 2) begin
        e = q3.pop_front();
        checks++; if (r3 !== e || c3 !== e[2]) begin errors++; $display("FAIL b2b_real3 got %b exp %b", r3, e); end
      end
    end
    S = 0;
    for (int k = 0; k < 4 && q3.size() > 0; k++) begin
      step();
      if (q2.size() > 0) begin
        e = q2.pop_front();
        checks++; if (r2 !== e) begin errors++; $display("FAIL b2b_drain2 got %b exp %b", r2, e); end
      end
      e = q3.pop_front();
      checks++; if (r3 !== e) begin errors++; $display("FAIL b2b_drain3 got %b exp %b", r3, e); end
    end
    checks++; if (b3 !== 1'b0 || b2 !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b/%b exp 0", b2, b3); end
  endtask

  initial begin
    test_reset();
    test_depth2();
    test_depth3();
    test_flush();
    test_save_restore();
    test_same_bank();
    test_save_vs_commit();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
